shift_add_multiplier: RTL
=========================

# shift_add_multiplier

Sequential unsigned 8×8 → 16-bit multiplier built around the team's 16-bit carry-lookahead adder (`carryLookAhead16bit`), which forms every partial-product accumulation. The block sits directly downstream of the adder: it consumes the adder's sum each cycle and feeds it back as the next accumulator value. It serves as the arithmetic core for datapath stages that need a product but cannot afford a combinational array multiplier.

## Interface
- No parameters; widths are fixed at 8-bit operands and a 16-bit product.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset. Clears all state immediately, independent of `clk`.
- `start`  input  1  request a multiply. Sampled only in IDLE.
- `a`  input  8  multiplicand, unsigned. Sampled on the accepting edge.
- `b`  input  8  multiplier, unsigned. Sampled on the accepting edge.
- `product`  output  16  accumulator contents. Valid when `done`=1, and held until the next accepted `start`.
- `busy`  output  1  high in RUN and DONE.
- `done`  output  1  high for exactly one cycle, in DONE.

## Operation
- Registers:
  - `mcand[15:0]`: `a` zero-extended.
  - `mplier[7:0]`: `b`.
  - `acc[15:0]`: accumulator.
  - `cnt[3:0]`: step counter.
  - `state[1:0]`.
- FSM states: IDLE=0, RUN=1, DONE=2. Encoding 3 is illegal and returns to IDLE on the next edge.
- **IDLE**
  - If `start`=1 at an edge: `mcand`←{8'h00,`a`}, `mplier`←`b`, `acc`←0, `cnt`←0, state←RUN.
  - Otherwise all registers hold.
- **RUN** (one step per edge):
  - If `mplier[0]`=1, `acc`←adder sum of `acc`+`mcand`, with cin=0. Otherwise `acc` holds.
  - `mcand`←`mcand`<<1 (zero fill). `mplier`←`mplier`>>1 (zero fill). `cnt`←`cnt`+1.
  - When `cnt`=7 at the edge (the 8th step), state←DONE.
- **DONE**: `done`=1; all data registers hold; state←IDLE on the next edge.
- `start` is ignored in RUN and DONE. There is no queueing; requests in those states are dropped.
- Adder instance wiring: a=`acc`, b=`mcand`, cin=0. Its `c16`, `pg` and `gg` are unused.
  - `c16` is always 0, because the maximum product 0xFE01 fits in 16 bits. The bench checks this.
- `product`=`acc` (direct register output, no extra stage).
- Outputs are decoded from `state`: `busy`=(state≠IDLE), `done`=(state==DONE).
- **Reset (any time, including mid-RUN):**
  - state←IDLE; `acc`, `mcand`, `mplier`, `cnt`←0.
  - The aborted operation is lost, with no partial `done`.
- Reset values of outputs: `product`=0, `busy`=0, `done`=0.
- `start` held high continuously starts a new operation in each IDLE cycle, giving one operation every 10 cycles.

## Timing
- Edge E0: `start`=1 sampled in IDLE. After E0: `busy`=1.
- Edges E1–E8: the eight RUN steps. State is DONE after E8.
- Cycle after E8: `done`=1, `busy`=1, `product` final.
- Edge E9: state→IDLE, `done`=0, `busy`=0. `product` still holds.
- Latency from the accepting edge to `done` asserted: 8 cycles.
- Minimum start-to-start interval: 10 edges (E0 and E10).
- The adder path is combinational within one cycle. The clock period must cover the CLA delay plus register setup.

## Test plan
- Reset then idle: assert `rst` for 2 cycles → `product`=0x0000, `busy`=0, `done`=0. No change for 20 cycles while `start`=0.
- Basic multiplies, issued back-to-back with `start` held high:
  - 0x0D×0x0B → 0x008F.
  - 0x80×0x02 → 0x0100.
  - 0x00×0xFF → 0x0000.
  - For each: `done` pulses exactly 1 cycle, 8 cycles after acceptance, and the next acceptance occurs 10 edges after the previous one.
- Maximum operands: 0xFF×0xFF → `product`=0xFE01 with `done`=1. The adder's `c16` stays 0 throughout.
- Start while busy: accept 0x03×0x05, then pulse `start` with a=0x77, b=0x77 at step 4 → result 0x000F. A single `done` is seen, and 0x77 is never computed.
- Mid-operation reset: accept 0xAA×0x55, assert `rst` asynchronously between edges E4 and E5 → outputs go to 0 immediately, with no `done`.
  - Then accept 0x12×0x34 → 0x03A8 after 8 cycles.
- Randomised: 500 random (`a`,`b`) pairs with random `start` gaps → `product`==`a`*`b` at every `done`. Total `done` count equals the number of accepted starts.

Source files
------------

// File: rtl/shift_add_multiplier_if.sv
// Request/result bundle for the shift-add multiplier.
// master issues operands, slave returns product and status.
interface shift_add_multiplier_if;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] product;
    logic        busy;
    logic        done;

    modport master (
        output start, a, b,
        input  product, busy, done
    );

    modport slave (
        input  start, a, b,
        output product, busy, done
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential 8x8 unsigned multiplier: one shift-add step per clock,
// accumulating through a two-level 16-bit carry-lookahead adder.
module carryLookAhead16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        c16,
    output logic        pg,
    output logic        gg
);
    logic [15:0] p, g, ci;
    logic [3:0]  gp, gg4;
    logic [4:0]  c;
    logic        carry;

    assign p = a ^ b;
    assign g = a & b;

    always_comb begin
        gp  = '0;
        gg4 = '0;
        for (int i = 0; i < 4; i++) begin
            gp[i]  = &p[4*i +: 4];
            gg4[i] = g[4*i+3]
                   | (p[4*i+3] & g[4*i+2])
                   | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                   | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
        end
    end

    // Group carries resolved in parallel from group generate/propagate
    assign c[0] = cin;
    assign c[1] = gg4[0] | (gp[0] & cin);
    assign c[2] = gg4[1] | (gp[1] & gg4[0]) | (gp[1] & gp[0] & cin);
    assign c[3] = gg4[2] | (gp[2] & gg4[1]) | (gp[2] & gp[1] & gg4[0])
                | (gp[2] & gp[1] & gp[0] & cin);
    assign c[4] = gg4[3] | (gp[3] & gg4[2]) | (gp[3] & gp[2] & gg4[1])
                | (gp[3] & gp[2] & gp[1] & gg4[0])
                | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

    always_comb begin
        ci    = '0;
        carry = 1'b0;
        for (int i = 0; i < 4; i++) begin
            carry = c[i];
            for (int j = 0; j < 4; j++) begin
                ci[4*i+j] = carry;
                carry     = g[4*i+j] | (p[4*i+j] & carry);
            end
        end
    end

    assign sum = p ^ ci;
    assign c16 = c[4];
    assign pg  = &gp;
    assign gg  = gg4[3] | (gp[3] & gg4[2]) | (gp[3] & gp[2] & gg4[1])
               | (gp[3] & gp[2] & gp[1] & gg4[0]);
endmodule

module shift_add_multiplier (
    input  logic                  clk,
    input  logic                  rst,
    shift_add_multiplier_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [15:0] mcand, acc, sum;
    logic [7:0]  mplier;
    logic [3:0]  cnt;
    logic        load, step;
    logic        c16, pg, gg;

    carryLookAhead16bit u_cla (
        .a   (acc),
        .b   (mcand),
        .cin (1'b0),
        .sum (sum),
        .c16 (c16),
        .pg  (pg),
        .gg  (gg)
    );

    // Carry-out cannot occur: 0xFF*0xFF fits in 16 bits
    logic unused_cla;
    assign unused_cla = &{1'b0, c16, pg, gg};

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == 4'd7)
                    state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            state <= state_n;
            unique case (1'b1)
                load: begin
                    mcand  <= {8'h00, bus.a};
                    mplier <= bus.b;
                    acc    <= '0;
                    cnt    <= '0;
                end
                step: begin
                    if (mplier[0])
                        acc <= sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.product = acc;
    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
endmodule
